// File: rtl/reg_file_ctrl.sv
// ---------------------------------------------------------------------------
// reg_file_ctrl
//
// Initiator side of a 2**ADDR_W x DATA_W register file. It takes one ALU
// command at a time, drives the two read addresses, samples the read data,
// computes a result and writes it back through WA / data_out / write_enable.
//
// Optional feature macro: REG_FILE_CTRL_FLAGS_EN
//   When defined, registered result flags flag_z, flag_c and flag_n are added.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_op               00 ADD, 01 SUB, 10 AND, 11 MOVI
//   cmd_rd/rs1/rs2       destination and source register addresses
//   cmd_imm              immediate (MOVI only)
//   RA1, RA2             register file read addresses
//   rd_data1, rd_data2   register file read data (combinational from RA1/RA2)
//   WA, data_out         register file write address / write data
//   write_enable         register file write strobe
//   done                 one-cycle pulse after the write-back commits
//   busy                 high in any state other than IDLE
//   flag_z/c/n           result flags (REG_FILE_CTRL_FLAGS_EN only)
//   dbg_state            current FSM state (0 IDLE, 1 READ, 2 EXEC, 3 WRITE)
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is high only in IDLE, so cmd_* are ignored
// while a command is in flight; the initiator may hold cmd_valid and its
// payload stable until the transfer edge.
// ---------------------------------------------------------------------------
module reg_file_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] RA1,
    output logic [ADDR_W-1:0] RA2,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    output logic [ADDR_W-1:0] WA,
    output logic [DATA_W-1:0] data_out,
    output logic              write_enable,
    output logic              done,
    output logic              busy,
`ifdef REG_FILE_CTRL_FLAGS_EN
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_n,
`endif
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MOVI = 2'b11;

    state_t            state;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] alu_result;

    assign dbg_state = state;

    // ALU on the live read data; only consumed in EXEC, after the READ
    // settle cycle has kept RA1/RA2 stable.
    always_comb begin
        alu_result = '0;
        case (op_q)
            OP_ADD:  alu_result = rd_data1 + rd_data2;
            OP_SUB:  alu_result = rd_data1 - rd_data2;
            OP_AND:  alu_result = rd_data1 & rd_data2;
            default: alu_result = '0;  // MOVI never reaches EXEC
        endcase
    end

`ifdef REG_FILE_CTRL_FLAGS_EN
    logic [DATA_W:0] add_wide;
    logic            alu_carry;

    assign add_wide = {1'b0, rd_data1} + {1'b0, rd_data2};

    // Carry out for ADD, unsigned borrow for SUB, zero otherwise.
    always_comb begin
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD:  alu_carry = add_wide[DATA_W];
            OP_SUB:  alu_carry = (rd_data1 < rd_data2);
            default: alu_carry = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op_q         <= OP_ADD;
            rd_q         <= '0;
            cmd_ready    <= 1'b1;
            RA1          <= '0;
            RA2          <= '0;
            WA           <= '0;
            data_out     <= '0;
            write_enable <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
`ifdef REG_FILE_CTRL_FLAGS_EN
            flag_z       <= 1'b0;
            flag_c       <= 1'b0;
            flag_n       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        rd_q      <= cmd_rd;
                        RA1       <= cmd_rs1;
                        RA2       <= cmd_rs2;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_op == OP_MOVI) begin
                            // Immediate goes straight to write-back.
                            data_out     <= cmd_imm;
                            WA           <= cmd_rd;
                            write_enable <= 1'b1;
                            state        <= WRITE;
`ifdef REG_FILE_CTRL_FLAGS_EN
                            flag_z       <= (cmd_imm == '0);
                            flag_n       <= cmd_imm[DATA_W-1];
                            flag_c       <= 1'b0;
`endif
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    state <= EXEC;
                end
                EXEC: begin
                    // Operands are sampled here, before the write in WRITE,
                    // so rd may alias rs1/rs2.
                    data_out     <= alu_result;
                    WA           <= rd_q;
                    write_enable <= 1'b1;
                    state        <= WRITE;
`ifdef REG_FILE_CTRL_FLAGS_EN
                    flag_z       <= (alu_result == '0);
                    flag_n       <= alu_result[DATA_W-1];
                    flag_c       <= alu_carry;
`endif
                end
                WRITE: begin
                    write_enable <= 1'b0;
                    done         <= 1'b1;
                    cmd_ready    <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_file_ctrl
//
// Directed bench for reg_file_ctrl with a behavioural 16 x 8 register file
// attached. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_reg_file_ctrl;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_rd;
    logic [3:0] cmd_rs1;
    logic [3:0] cmd_rs2;
    logic [7:0] cmd_imm;
    logic [3:0] RA1;
    logic [3:0] RA2;
    logic [7:0] rd_data1;
    logic [7:0] rd_data2;
    logic [3:0] WA;
    logic [7:0] data_out;
    logic       write_enable;
    logic       done;
    logic       busy;
    logic [1:0] dbg_state;
`ifdef REG_FILE_CTRL_FLAGS_EN
    logic       flag_z;
    logic       flag_c;
    logic       flag_n;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Register file model: combinational read, write on rising edge.
    logic [7:0] rf [16] = '{default: 8'h00};
    assign rd_data1 = rf[RA1];
    assign rd_data2 = rf[RA2];
    always @(posedge clk) begin
        if (write_enable === 1'b1) rf[WA] <= data_out;
    end

    // Count write strobes seen at clock edges.
    logic we_clr;
    int   we_cnt;
    always @(posedge clk) begin
        if (we_clr) we_cnt <= 0;
        else if (write_enable === 1'b1) we_cnt <= we_cnt + 1;
    end

    reg_file_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_rd       (cmd_rd),
        .cmd_rs1      (cmd_rs1),
        .cmd_rs2      (cmd_rs2),
        .cmd_imm      (cmd_imm),
        .RA1          (RA1),
        .RA2          (RA2),
        .rd_data1     (rd_data1),
        .rd_data2     (rd_data2),
        .WA           (WA),
        .data_out     (data_out),
        .write_enable (write_enable),
        .done         (done),
        .busy         (busy),
`ifdef REG_FILE_CTRL_FLAGS_EN
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .flag_n       (flag_n),
`endif
        .dbg_state    (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one command for a single accept edge, then drop cmd_valid.
    task automatic issue(input logic [1:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [7:0] imm);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        cmd_imm   = imm;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_rd    = 4'd0;
        cmd_rs1   = 4'd0;
        cmd_rs2   = 4'd0;
        cmd_imm   = 8'h00;
        we_clr    = 1'b1;

        // ---- reset ----
        tick();
        tick();
        reset = 1'b0;
        tick();
        we_clr = 1'b0;
        check("rst_ready", 32'(cmd_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_we", 32'(write_enable), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ra1", 32'(RA1), 32'h0);
        check("rst_ra2", 32'(RA2), 32'h0);
        check("rst_wa", 32'(WA), 32'h0);
        check("rst_dout", 32'(data_out), 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);

        // ---- MOVI r3 = 2A ----
        issue(2'b11, 4'd3, 4'd0, 4'd0, 8'h2A);
        check("movi_we", 32'(write_enable), 32'h1);
        check("movi_wa", 32'(WA), 32'h3);
        check("movi_dout", 32'(data_out), 32'h2A);
        check("movi_busy", 32'(busy), 32'h1);
        check("movi_ready", 32'(cmd_ready), 32'h0);
        check("movi_done0", 32'(done), 32'h0);
`ifdef REG_FILE_CTRL_FLAGS_EN
        check("movi_fz", 32'(flag_z), 32'h0);
`endif
        tick();
        check("movi_done", 32'(done), 32'h1);
        check("movi_we_off", 32'(write_enable), 32'h0);
        check("movi_ready1", 32'(cmd_ready), 32'h1);
        check("movi_r3", 32'(rf[3]), 32'h2A);
        tick();
        check("movi_done_off", 32'(done), 32'h0);

        // ---- preload r1 = F0, r2 = 20 ----
        issue(2'b11, 4'd1, 4'd0, 4'd0, 8'hF0);
        tick();
        issue(2'b11, 4'd2, 4'd0, 4'd0, 8'h20);
        tick();
        check("pre_r1", 32'(rf[1]), 32'hF0);
        check("pre_r2", 32'(rf[2]), 32'h20);

        // ---- ADD r4 = r1 + r2 = 10 (carry) ----
        issue(2'b00, 4'd4, 4'd1, 4'd2, 8'h00);
        check("add_read_state", 32'(dbg_state), 32'h1);
        check("add_read_ra1", 32'(RA1), 32'h1);
        check("add_read_ra2", 32'(RA2), 32'h2);
        check("add_read_we", 32'(write_enable), 32'h0);
        tick();
        check("add_exec_ra1", 32'(RA1), 32'h1);
        check("add_exec_ra2", 32'(RA2), 32'h2);
        check("add_exec_we", 32'(write_enable), 32'h0);
        tick();
        check("add_wr_we", 32'(write_enable), 32'h1);
        check("add_wr_wa", 32'(WA), 32'h4);
        check("add_wr_dout", 32'(data_out), 32'h10);
        check("add_wr_done", 32'(done), 32'h0);
`ifdef REG_FILE_CTRL_FLAGS_EN
        check("add_fc", 32'(flag_c), 32'h1);
        check("add_fz", 32'(flag_z), 32'h0);
        check("add_fn", 32'(flag_n), 32'h0);
`endif
        tick();
        check("add_done", 32'(done), 32'h1);
        check("add_r4", 32'(rf[4]), 32'h10);

        // ---- SUB r1 = r1 - r1 with r1 = 05 ----
        issue(2'b11, 4'd1, 4'd0, 4'd0, 8'h05);
        tick();
        issue(2'b01, 4'd1, 4'd1, 4'd1, 8'h00);
        tick();
        tick();
        check("sub0_we", 32'(write_enable), 32'h1);
        check("sub0_wa", 32'(WA), 32'h1);
        check("sub0_dout", 32'(data_out), 32'h00);
`ifdef REG_FILE_CTRL_FLAGS_EN
        check("sub0_fz", 32'(flag_z), 32'h1);
        check("sub0_fc", 32'(flag_c), 32'h0);
`endif
        tick();
        check("sub0_r1", 32'(rf[1]), 32'h00);

        // ---- SUB r5 = r4 - r2 = 10 - 20 = F0 (wrap, borrow) ----
        issue(2'b01, 4'd5, 4'd4, 4'd2, 8'h00);
        tick();
        tick();
        check("subw_dout", 32'(data_out), 32'hF0);
`ifdef REG_FILE_CTRL_FLAGS_EN
        check("subw_fc", 32'(flag_c), 32'h1);
        check("subw_fn", 32'(flag_n), 32'h1);
        check("subw_fz", 32'(flag_z), 32'h0);
`endif
        tick();
        check("subw_r5", 32'(rf[5]), 32'hF0);

        // ---- AND r6 = r2 & r3 = 20, then MOVI r7 = 5A, valid held ----
        we_clr = 1'b1;
        tick();
        we_clr = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_rd    = 4'd6;
        cmd_rs1   = 4'd2;
        cmd_rs2   = 4'd3;
        tick();                                   // AND accepted
        cmd_op  = 2'b11;                          // MOVI presented while busy
        cmd_rd  = 4'd7;
        cmd_imm = 8'h5A;
        check("bb_c1_state", 32'(dbg_state), 32'h1);
        check("bb_c1_busy", 32'(busy), 32'h1);
        tick();
        check("bb_c2_state", 32'(dbg_state), 32'h2);
        tick();
        check("bb_c3_we", 32'(write_enable), 32'h1);
        check("bb_c3_wa", 32'(WA), 32'h6);
        check("bb_c3_dout", 32'(data_out), 32'h20);
        tick();
        check("bb_c4_done", 32'(done), 32'h1);
        check("bb_c4_ready", 32'(cmd_ready), 32'h1);
        check("bb_c4_state", 32'(dbg_state), 32'h0);
        tick();                                   // MOVI accepted
        cmd_valid = 1'b0;
        check("bb_c5_we", 32'(write_enable), 32'h1);
        check("bb_c5_wa", 32'(WA), 32'h7);
        check("bb_c5_dout", 32'(data_out), 32'h5A);
        tick();
        check("bb_c6_done", 32'(done), 32'h1);
        tick();
        tick();
        check("bb_we_pulses", 32'(we_cnt), 32'd2);
        check("bb_r6", 32'(rf[6]), 32'h20);
        check("bb_r7", 32'(rf[7]), 32'h5A);

        // ---- reset during READ of ADD r8 = r1 + r2 ----
        we_clr = 1'b1;
        tick();
        we_clr = 1'b0;
        issue(2'b00, 4'd8, 4'd1, 4'd2, 8'h00);
        check("rr_pre_state", 32'(dbg_state), 32'h1);
        reset = 1'b1;
        #1;
        check("rr_state", 32'(dbg_state), 32'h0);
        check("rr_ready", 32'(cmd_ready), 32'h1);
        check("rr_busy", 32'(busy), 32'h0);
        check("rr_we", 32'(write_enable), 32'h0);
        check("rr_ra1", 32'(RA1), 32'h0);
        check("rr_ra2", 32'(RA2), 32'h0);
        check("rr_wa", 32'(WA), 32'h0);
        check("rr_dout", 32'(data_out), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("rr_we_pulses", 32'(we_cnt), 32'd0);
        check("rr_r8", 32'(rf[8]), 32'h00);
        check("rr_r1", 32'(rf[1]), 32'h00);
        check("rr_r2", 32'(rf[2]), 32'h20);
        check("rr_idle", 32'(dbg_state), 32'h0);

        // ---- report ----
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_ctrl.md
Name: reg_file_ctrl

Overview:
Initiator side of the 16 x 8-bit register file interface. Accepts one ALU command at a time over a valid/ready handshake and drives the register file read addresses. It samples the two read ports, computes an 8-bit result, and writes it back through the write address, data and enable pins. Sits between the lab's instruction source (switches or sequencer) and the register file, and lets the register file be exercised as a tiny datapath.

Parameters:
DATA_W, 8, data width of register file and ALU
ADDR_W, 4, register address width (2**ADDR_W registers)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept command (high only in IDLE)
cmd_op  input  2  00 ADD, 01 SUB, 10 AND, 11 MOVI
cmd_rd  input  ADDR_W  destination register
cmd_rs1  input  ADDR_W  source register 1
cmd_rs2  input  ADDR_W  source register 2
cmd_imm  input  DATA_W  immediate, used by MOVI only
RA1  output  ADDR_W  register file read address 1
RA2  output  ADDR_W  register file read address 2
rd_data1  input  DATA_W  register file read data 1 (combinational from RA1)
rd_data2  input  DATA_W  register file read data 2 (combinational from RA2)
WA  output  ADDR_W  register file write address
data_out  output  DATA_W  register file write data
write_enable  output  1  register file write strobe
done  output  1  one-cycle pulse: write-back committed
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-high, named reset.
- All outputs are registered.
- Reset values:
  - state = IDLE
  - cmd_ready = 1
  - RA1, RA2, WA, data_out = 0
  - write_enable, done, busy = 0
- Register file contract:
  - Read data is valid in the same cycle as the address.
  - A write commits on the rising clk edge while write_enable = 1.
- FSM states: IDLE, READ, EXEC, WRITE.
  - IDLE: cmd_ready = 1. On cmd_valid & cmd_ready at an edge:
    - latch op, rd and imm; load RA1 = cmd_rs1, RA2 = cmd_rs2.
    - op = MOVI -> WRITE, with data_out = cmd_imm and WA = cmd_rd.
    - otherwise -> READ.
  - READ: one settle cycle; RA1 and RA2 are held stable. -> EXEC.
  - EXEC: sample rd_data1 and rd_data2 and compute the result into data_out; set WA = rd. -> WRITE.
    - ADD = (a + b) mod 2^DATA_W
    - SUB = (a - b) mod 2^DATA_W (two's complement wrap)
    - AND = a & b
  - WRITE: write_enable = 1 for exactly this one cycle. At the exit edge, done pulses for 1 cycle. -> IDLE.
- Latency from the accept edge to the done pulse:
  - ADD/SUB/AND: 3 cycles (write commits at the end of WRITE).
  - MOVI: 1 cycle.
- Back-to-back commands:
  - A new command is accepted in the IDLE cycle following done; minimum issue interval is 4 cycles for ALU ops and 2 for MOVI.
  - cmd_* inputs are ignored while busy = 1.
- rd equal to rs1 or rs2 is legal: the operands are sampled in EXEC, before the write in WRITE.
- RA1 and RA2 keep their last values in IDLE; they do not return to 0.
- Reset asserted mid-operation:
  - immediate return to IDLE with the reset values above;
  - write_enable drops asynchronously, so no partial write is issued.
- An unused encoding cannot occur, because the 2-bit op space is fully decoded.

Optional Feature:
Macro REG_FILE_CTRL_FLAGS_EN.
- When defined, add outputs flag_z (1), flag_c (1) and flag_n (1). They are registered and updated at the EXEC->WRITE edge (for MOVI, at the IDLE->WRITE edge):
  - flag_z = (result == 0)
  - flag_n = result[DATA_W-1]
  - flag_c = carry out of ADD; borrow (a < b unsigned) for SUB; 0 for AND and MOVI.
  - Reset value of all flags is 0; they hold between commands.
- When undefined, these ports do not exist and behaviour is otherwise identical.

Test Plan:
- Reset held 2 cycles, then released -> cmd_ready = 1, busy = 0, write_enable = 0, RA1 = RA2 = WA = 0, data_out = 0.
- MOVI rd = 3, imm = 8'h2A -> next cycle write_enable = 1, WA = 3, data_out = 8'h2A; done pulses 1 cycle later; the register file model then holds r3 = 8'h2A.
- With r1 = 8'hF0 and r2 = 8'h20, ADD rd = 4, rs1 = 1, rs2 = 2 -> RA1 = 1 and RA2 = 2 during READ and EXEC; write_enable is high only in cycle 3 with WA = 4 and data_out = 8'h10; with FLAGS_EN, flag_c = 1 and flag_z = 0.
- SUB rd = 1, rs1 = 1, rs2 = 1 with r1 = 8'h05 -> data_out = 8'h00 written to r1; with FLAGS_EN, flag_z = 1 and flag_c = 0.
- Issue AND then MOVI, holding cmd_valid high throughout -> the second command is accepted only in the IDLE cycle after the first done; busy = 1 blocks acceptance; exactly two write_enable pulses occur.
- Assert reset during READ of an ADD -> outputs return to reset values immediately; write_enable is never asserted; no register changes.
